// File: rtl/noc_output_arbiter_if.sv
// Handshake bundle between the requesting input ports and one router output arbiter.
// master: the requesters and the downstream flit interface. slave: the arbiter.
interface noc_output_arbiter_if #(
    parameter int REQUESTS = 5
) ();
    localparam int INDEX_WIDTH = (REQUESTS > 1) ? $clog2(REQUESTS) : 1;

    logic [REQUESTS-1:0]    i_request;
    logic [REQUESTS-1:0]    i_valid;
    logic [REQUESTS-1:0]    i_tail;
    logic                   i_ready;
    logic [REQUESTS-1:0]    o_grant;
    logic [INDEX_WIDTH-1:0] o_select;
    logic                   o_valid;
    logic [REQUESTS-1:0]    o_ready;
    logic                   o_busy;

    modport master (
        output i_request, i_valid, i_tail, i_ready,
        input  o_grant, o_select, o_valid, o_ready, o_busy
    );

    modport slave (
        input  i_request, i_valid, i_tail, i_ready,
        output o_grant, o_select, o_valid, o_ready, o_busy
    );
endinterface

// File: rtl/noc_output_arbiter.sv
// Packet-granular round-robin arbiter for one router output port. A granted
// requester owns the output until its tail flit transfers; the next owner is
// chosen in the same cycle so packets can go back-to-back.
module noc_output_arbiter #(
    parameter int REQUESTS = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    noc_output_arbiter_if.slave  bus
);
    localparam int INDEX_WIDTH = (REQUESTS > 1) ? $clog2(REQUESTS) : 1;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e                 state_q, state_d;
    logic [REQUESTS-1:0]    grant_q, grant_d;
    logic [INDEX_WIDTH-1:0] select_q, select_d;
    logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;

    logic                   win_found;
    logic [INDEX_WIDTH-1:0] win_idx;
    logic [REQUESTS-1:0]    win_onehot;
    logic [INDEX_WIDTH-1:0] win_next_ptr;
    logic [INDEX_WIDTH-1:0] cand;
    logic                   tail_xfer;

    // Tail of the owner's packet leaves this cycle; grant_q is zero when idle.
    always_comb begin
        tail_xfer = (|(grant_q & bus.i_valid & bus.i_tail)) & bus.i_ready;
    end

    // Round-robin search upward from ptr_q with wrap. Since ptr_q sits one past
    // the current owner, the owner's own request naturally ranks last.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        cand       = '0;
        for (int i = 0; i < REQUESTS; i++) begin
            cand = INDEX_WIDTH'((int'(ptr_q) + i) % REQUESTS);
            if (!win_found && bus.i_request[cand]) begin
                win_found        = 1'b1;
                win_idx          = cand;
                win_onehot[cand] = 1'b1;
            end
        end
        win_next_ptr = (win_idx == INDEX_WIDTH'(REQUESTS - 1)) ? '0
                                                                : win_idx + INDEX_WIDTH'(1);
    end

    // Next-state logic: arbitrate from idle, or re-arbitrate on a tail transfer.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        select_d = select_q;
        ptr_d    = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d  = StBusy;
                    grant_d  = win_onehot;
                    select_d = win_idx;
                    ptr_d    = win_next_ptr;
                end
            end
            StBusy: begin
                if (tail_xfer) begin
                    if (win_found) begin
                        grant_d  = win_onehot;
                        select_d = win_idx;
                        ptr_d    = win_next_ptr;
                    end else begin
                        state_d  = StIdle;
                        grant_d  = '0;
                        select_d = '0;
                    end
                end
            end
            default: begin
                state_d  = StIdle;
                grant_d  = '0;
                select_d = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset drops any grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            select_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            select_q <= select_d;
            ptr_q    <= ptr_d;
        end
    end

    // Output handshake is combinational from the registered grant.
    always_comb begin
        bus.o_grant  = grant_q;
        bus.o_select = select_q;
        bus.o_busy   = (state_q == StBusy);
        bus.o_valid  = |(grant_q & bus.i_valid);
        bus.o_ready  = grant_q & {REQUESTS{bus.i_ready}};
    end
endmodule

// File: tb/tb_noc_output_arbiter.sv
// Self-checking bench for noc_output_arbiter: directed packet scenarios plus a
// random phase, with a per-cycle expectation queue fed by a small packet model.
module tb_noc_output_arbiter;
    localparam int N = 5;

    typedef struct packed {
        logic [N-1:0] grant;
        logic [2:0]   sel;
        logic         busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    noc_output_arbiter_if #(.REQUESTS(N)) bus ();

    noc_output_arbiter #(.REQUESTS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    // Reference packet model state.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] v;
        v = '0;
        v[idx[2:0]] = 1'b1;
        return v;
    endfunction

    // Drive one cycle of inputs, check the combinational outputs, predict the
    // registered outcome of the coming edge, then compare after the edge.
    task automatic drive(input logic [N-1:0] req, input logic [N-1:0] val,
                         input logic [N-1:0] tail, input logic rdy);
        exp_t e;
        exp_t g;
        bit   tail_x;
        int   win;
        int   c;
        bus.i_request = req;
        bus.i_valid   = val;
        bus.i_tail    = tail;
        bus.i_ready   = rdy;
        #1;
        check_eq("o_valid", 32'(bus.o_valid), m_busy ? 32'(val[m_owner[2:0]]) : 32'd0);
        check_eq("o_ready", 32'(bus.o_ready), (m_busy && rdy) ? 32'(onehot(m_owner)) : 32'd0);

        tail_x = m_busy && val[m_owner[2:0]] && tail[m_owner[2:0]] && rdy;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ptr  = 0;
        end else if (!m_busy || tail_x) begin
            win = -1;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (win < 0 && req[c[2:0]]) win = c;
            end
            if (win >= 0) begin
                m_busy  = 1'b1;
                m_owner = win;
                m_ptr   = (win + 1) % N;
            end else begin
                m_busy = 1'b0;
            end
        end
        e.grant = m_busy ? onehot(m_owner) : '0;
        e.sel   = m_busy ? 3'(m_owner) : 3'd0;
        e.busy  = m_busy;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got=0 entries expected=1");
        end else begin
            g = sb_q.pop_front();
            check_eq("grant", 32'(bus.o_grant), 32'(g.grant));
            check_eq("select", 32'(bus.o_select), 32'(g.sel));
            check_eq("busy", 32'(bus.o_busy), 32'(g.busy));
        end
    endtask

    logic [N-1:0] order [6];

    initial begin
        order = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        bus.i_request = '0;
        bus.i_valid   = '0;
        bus.i_tail    = '0;
        bus.i_ready   = 1'b0;

        // Reset.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        drive(5'b00000, 5'b00000, 5'b00000, 1'b0);
        drive(5'b11111, 5'b11111, 5'b11111, 1'b1);
        check_eq("rst_grant", 32'(bus.o_grant), 32'd0);
        check_eq("rst_select", 32'(bus.o_select), 32'd0);
        check_eq("rst_busy", 32'(bus.o_busy), 32'd0);
        check_eq("rst_valid", 32'(bus.o_valid), 32'd0);
        check_eq("rst_ready", 32'(bus.o_ready), 32'd0);
        rst_n = 1'b1;

        // First arbitration after reset picks requester 2 from 10100.
        drive(5'b10100, 5'b00000, 5'b00000, 1'b1);
        check_eq("first_grant", 32'(bus.o_grant), 32'b00100);
        check_eq("first_select", 32'(bus.o_select), 32'd2);
        check_eq("first_busy", 32'(bus.o_busy), 32'd1);

        // Three-flit packet from owner 2 with a stall on flit 2; requester 4 waits.
        drive(5'b10000, 5'b00100, 5'b00000, 1'b1);
        check_eq("pkt_hold1", 32'(bus.o_grant), 32'b00100);
        drive(5'b10000, 5'b00100, 5'b00000, 1'b0);
        check_eq("pkt_stall", 32'(bus.o_grant), 32'b00100);
        drive(5'b10000, 5'b00100, 5'b00000, 1'b1);
        check_eq("pkt_hold2", 32'(bus.o_grant), 32'b00100);
        drive(5'b10000, 5'b00100, 5'b00100, 1'b1);
        check_eq("b2b_grant", 32'(bus.o_grant), 32'b10000);
        check_eq("b2b_busy", 32'(bus.o_busy), 32'd1);
        drive(5'b00000, 5'b10000, 5'b10000, 1'b1);
        check_eq("release_idle", 32'(bus.o_busy), 32'd0);

        // All five request single-flit packets; valid on every second cycle.
        drive(5'b11111, 5'b00000, 5'b11111, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check_eq("rr_order", 32'(bus.o_grant), 32'(order[i]));
            drive(5'b11111, 5'b00000, 5'b11111, 1'b1);
            check_eq("rr_hold", 32'(bus.o_grant), 32'(order[i]));
            if (i < 5) drive(5'b11111, 5'b11111, 5'b11111, 1'b1);
        end
        drive(5'b00000, 5'b11111, 5'b11111, 1'b1);
        check_eq("rr_idle", 32'(bus.o_grant), 32'd0);

        // Owner 1 pauses valid for three cycles while requester 0 waits.
        drive(5'b00010, 5'b00000, 5'b00000, 1'b1);
        check_eq("gap_grant", 32'(bus.o_grant), 32'b00010);
        drive(5'b00011, 5'b00010, 5'b00000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(5'b00001, 5'b00000, 5'b00000, 1'b1);
            check_eq("gap_hold", 32'(bus.o_grant), 32'b00010);
            check_eq("gap_valid", 32'(bus.o_valid), 32'd0);
        end
        drive(5'b00001, 5'b00010, 5'b00010, 1'b1);
        check_eq("gap_next", 32'(bus.o_grant), 32'b00001);
        drive(5'b00000, 5'b00001, 5'b00001, 1'b1);

        // Reset in the middle of owner 3's packet.
        drive(5'b01000, 5'b00000, 5'b00000, 1'b1);
        check_eq("mid_grant", 32'(bus.o_grant), 32'b01000);
        drive(5'b01000, 5'b01000, 5'b00000, 1'b1);
        rst_n = 1'b0;
        drive(5'b01000, 5'b01000, 5'b00000, 1'b1);
        check_eq("mid_rst_grant", 32'(bus.o_grant), 32'd0);
        check_eq("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        rst_n = 1'b1;
        drive(5'b01001, 5'b00000, 5'b00000, 1'b1);
        check_eq("post_rst_grant", 32'(bus.o_grant), 32'b00001);
        drive(5'b00000, 5'b00001, 5'b00001, 1'b1);

        // Owner 4 alone re-requests on its tail; pointer then wraps to 0.
        drive(5'b10000, 5'b00000, 5'b00000, 1'b1);
        check_eq("self_grant", 32'(bus.o_grant), 32'b10000);
        drive(5'b10000, 5'b10000, 5'b10000, 1'b1);
        check_eq("self_regrant", 32'(bus.o_grant), 32'b10000);
        drive(5'b11111, 5'b10000, 5'b10000, 1'b1);
        check_eq("self_wrap", 32'(bus.o_grant), 32'b00001);
        drive(5'b00000, 5'b00001, 5'b00001, 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            drive(N'($urandom), N'($urandom), N'($urandom), ($urandom_range(0, 3) != 0));
        end
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
